filter_ctrl: RTL
================

FILTER_CTRL -- requirements
Module: filter_ctrl

Interface
REQ-001 Parameter FILT_LAT, default 1: cycles from f_x driven to the corresponding f_y.
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles f_rst is held during a flush.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 s_valid  in  1  input sample valid.
REQ-006 s_ready  out  1  input sample accepted when s_valid and s_ready are both high.
REQ-007 s_data  in  16  input sample, Q8.8 sign-magnitude.
REQ-008 m_valid  out  1  m_data is a valid filter output.
REQ-009 m_data  out  16  filter output, Q8.8 sign-magnitude.
REQ-010 cfg_we  in  1  coefficient shadow write strobe.
REQ-011 cfg_addr  in  2  coefficient select: 0=a1, 1=b0, 2=b1, 3=reserved.
REQ-012 cfg_wdata  in  16  coefficient write data, Q8.8 sign-magnitude.
REQ-013 cfg_commit  in  1  copy all shadow coefficients to active.
REQ-014 flush  in  1  clear filter history.
REQ-015 busy  out  1  high in FLUSH.
REQ-016 underrun  out  8  saturating count of RUN cycles with no accepted sample.

Function
REQ-017 States: IDLE, RUN, FLUSH.
REQ-018 IDLE: f_rst=1, s_ready=1, m_valid=0; an accepted sample moves to RUN and is driven on f_x in the next cycle.
REQ-019 RUN: f_rst=0, s_ready=1; each cycle f_x takes the accepted s_data, otherwise holds the last sample (zero-order hold) and underrun increments, saturating at 255.
REQ-020 m_valid rises FILT_LAT cycles after RUN entry and stays high while in RUN; m_data=f_y.
REQ-021 flush in any state enters FLUSH next cycle: f_rst=1, s_ready=0, m_valid=0, busy=1 for exactly FLUSH_CYCLES cycles, then IDLE.
REQ-022 flush asserted while in FLUSH restarts the FLUSH_CYCLES count.
REQ-023 cfg_we writes cfg_wdata into the shadow register at cfg_addr; writes to address 3 are ignored.
REQ-024 cfg_commit copies all three shadows to the active registers on the same edge; active registers drive f_a1/f_b0/f_b1.
REQ-025 cfg_we together with cfg_commit: the new write data reaches the active register on that edge (write-through).
REQ-026 Commit is honoured in every state, including during FLUSH.
REQ-027 Coefficients pass through unmodified; the block performs no arithmetic on data.
REQ-028 Underrun clears on flush.

Reset
REQ-029 On rst: state IDLE, shadow and active coefficients 0, held sample 0, underrun 0, m_valid 0, busy 0, f_rst 1.
REQ-030 rst mid-RUN or mid-FLUSH aborts immediately to IDLE; flush is ignored while rst is high.

Configuration
REQ-031 With FILT_COEF_READBACK_EN defined: output port cfg_rdata (16 bit) carries the active coefficient at cfg_addr, registered with 1-cycle latency, and reads 0 for address 3.
REQ-032 Without FILT_COEF_READBACK_EN: the cfg_rdata port and its logic are absent; all other behaviour is identical.

Structure
REQ-033 Package filter_pkg: coefficient address enum (ADDR_A1, ADDR_B0, ADDR_B1), state enum, 16-bit sample typedef, default FILT_LAT and FLUSH_CYCLES constants.
REQ-034 Sub-module: the existing filter block, instantiated as u_filter.
REQ-035 Port mapping: clk; rst = rst OR f_rst; x = f_x; a1, b0, b1 = active coefficients; y = f_y.

Verification
REQ-036 Write a1=0x80D2, b0=0x0016, b1=0x0016, commit, stream x=0x0300 -> m_valid at RUN+1 and m_data=0x000B.
REQ-037 Continue stream with x=0x0333 -> m_data=0x0023 on the following output.
REQ-038 Drop s_valid for 300 cycles in RUN -> f_x holds the last sample, underrun=255 (saturated), m_valid stays 1.
REQ-039 flush during RUN -> busy=1 and s_ready=0 for exactly 2 cycles, then IDLE with underrun=0 and m_valid=0.
REQ-040 cfg_we on address 1 with 0x0020 plus cfg_commit in the same cycle -> active b0=0x0020 next cycle; write to address 3 -> no register changes.
REQ-041 rst asserted mid-FLUSH -> next cycle IDLE, all coefficients 0, f_rst=1; with FILT_COEF_READBACK_EN, cfg_rdata=0 for every address.

Source files
------------

// File: rtl/filter_pkg.sv
// Shared types and defaults for the filter controller and its filter core.
package filter_pkg;

    typedef logic [15:0] sample_t;

    typedef enum logic [1:0] {
        ADDR_A1 = 2'd0,
        ADDR_B0 = 2'd1,
        ADDR_B1 = 2'd2
    } coef_addr_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int FILT_LAT_DEF     = 1;
    localparam int FLUSH_CYCLES_DEF = 2;

endpackage

// File: rtl/filter_ctrl_iir.sv
// Filter core: integrator driven by a 2-tap FIR scaled by (1 + a1), all I/O in Q8.8
// sign-magnitude, one cycle from x to y. History clears on rst.
module filter_ctrl_iir #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic [COEF_W-1:0] a1,
    input  logic [COEF_W-1:0] b0,
    input  logic [COEF_W-1:0] b1,
    output logic [DATA_W-1:0] y
);

    localparam int FRAC   = 8;
    localparam int GAIN_W = COEF_W + 1;
    localparam int PROD_W = DATA_W + GAIN_W;
    localparam int FIR_W  = PROD_W + 1;
    localparam int MAC_W  = FIR_W + GAIN_W;

    localparam logic signed [GAIN_W-1:0] ONE_G  = GAIN_W'(1 << FRAC);
    localparam logic signed [DATA_W-1:0] D_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [MAC_W-1:0]  SAT_HI = MAC_W'(D_MAX);
    localparam logic signed [MAC_W-1:0]  SAT_LO = -SAT_HI;

    function automatic logic signed [DATA_W-1:0] data_to_s(input logic [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] m;
        m = signed'({1'b0, v[DATA_W-2:0]});
        return v[DATA_W-1] ? -m : m;
    endfunction

    function automatic logic signed [GAIN_W-1:0] coef_to_s(input logic [COEF_W-1:0] v);
        logic signed [GAIN_W-1:0] m;
        m = signed'({2'b00, v[COEF_W-2:0]});
        return v[COEF_W-1] ? -m : m;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [MAC_W-1:0] v);
        if (v > SAT_HI) return D_MAX;
        if (v < SAT_LO) return -D_MAX;
        return DATA_W'(v);
    endfunction

    function automatic logic [DATA_W-1:0] s_to_data(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] m;
        m = v[DATA_W-1] ? -v : v;
        return {v[DATA_W-1], m[DATA_W-2:0]};
    endfunction

    logic signed [DATA_W-1:0] x_s_p0;
    logic signed [DATA_W-1:0] x1_p1;
    logic signed [DATA_W-1:0] acc_p1;
    logic signed [GAIN_W-1:0] gain_p0;
    logic signed [PROD_W-1:0] prod0_p0;
    logic signed [PROD_W-1:0] prod1_p0;
    logic signed [FIR_W-1:0]  fir_p0;
    logic signed [MAC_W-1:0]  mac_p0;
    logic signed [MAC_W-1:0]  sum_p0;

    // Stage p0: full-precision MAC; the Q8.8 x Q8.8 x Q8.8 product carries 16 extra fraction bits
    assign x_s_p0   = data_to_s(x);
    assign gain_p0  = coef_to_s(a1) + ONE_G;
    assign prod0_p0 = PROD_W'(x_s_p0) * PROD_W'(coef_to_s(b0));
    assign prod1_p0 = PROD_W'(x1_p1) * PROD_W'(coef_to_s(b1));
    assign fir_p0   = FIR_W'(prod0_p0) + FIR_W'(prod1_p0);
    assign mac_p0   = MAC_W'(fir_p0) * MAC_W'(gain_p0);
    assign sum_p0   = MAC_W'(acc_p1) + (mac_p0 >>> (2 * FRAC));

    // Stage p1: history registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x1_p1  <= '0;
            acc_p1 <= '0;
        end else begin
            x1_p1  <= x_s_p0;
            acc_p1 <= sat_data(sum_p0);
        end
    end

    assign y = s_to_data(acc_p1);

endmodule

// File: rtl/filter_ctrl.sv
// Sample/coefficient controller around the filter core. Define FILT_COEF_READBACK_EN
// to add the registered cfg_rdata readback port.
module filter_ctrl
    import filter_pkg::*;
#(
    parameter int FILT_LAT     = FILT_LAT_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [15:0] s_data,
    output logic        m_valid,
    output logic [15:0] m_data,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [15:0] cfg_wdata,
    input  logic        cfg_commit,
    input  logic        flush,
    output logic        busy,
`ifdef FILT_COEF_READBACK_EN
    output logic [15:0] cfg_rdata,
`endif
    output logic [7:0]  underrun
);

    localparam int LAT_W = (FILT_LAT > 0) ? $clog2(FILT_LAT + 1) : 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FILT_LAT);
    localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
    localparam logic [FC_W-1:0]  FC_LOAD  = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);

    state_e           state;
    sample_t          f_x;
    sample_t          f_y;
    logic             f_rst;
    logic [LAT_W-1:0] lat_cnt;
    logic [FC_W-1:0]  flush_cnt;
    sample_t          coef_shd [3];
    sample_t          coef_act [3];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            f_x       <= '0;
            f_rst     <= 1'b1;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            busy      <= 1'b0;
            underrun  <= '0;
            lat_cnt   <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            state     <= ST_FLUSH;
            f_rst     <= 1'b1;
            s_ready   <= 1'b0;
            m_valid   <= 1'b0;
            busy      <= 1'b1;
            underrun  <= '0;
            flush_cnt <= FC_LOAD;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (s_valid) begin
                        state   <= ST_RUN;
                        f_x     <= s_data;
                        f_rst   <= 1'b0;
                        lat_cnt <= LAT_LOAD;
                        m_valid <= (FILT_LAT == 0);
                    end
                end
                ST_RUN: begin
                    // Zero-order hold: without a new sample f_x keeps its last value
                    if (s_valid) begin
                        f_x <= s_data;
                    end else if (underrun != 8'hFF) begin
                        underrun <= underrun + 8'd1;
                    end
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_ONE;
                        if (lat_cnt == LAT_ONE) m_valid <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state   <= ST_IDLE;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A write that coincides with commit goes straight through to the active bank
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                coef_shd[i] <= '0;
                coef_act[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cfg_we && cfg_addr == 2'(i)) coef_shd[i] <= cfg_wdata;
                if (cfg_commit) begin
                    coef_act[i] <= (cfg_we && cfg_addr == 2'(i)) ? cfg_wdata : coef_shd[i];
                end
            end
        end
    end

`ifdef FILT_COEF_READBACK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_rdata <= '0;
        end else begin
            case (cfg_addr)
                ADDR_A1: cfg_rdata <= coef_act[0];
                ADDR_B0: cfg_rdata <= coef_act[1];
                ADDR_B1: cfg_rdata <= coef_act[2];
                default: cfg_rdata <= '0;
            endcase
        end
    end
`endif

    filter_ctrl_iir #(
        .DATA_W (16),
        .COEF_W (16)
    ) u_filter (
        .clk (clk),
        .rst (rst | f_rst),
        .x   (f_x),
        .a1  (coef_act[0]),
        .b0  (coef_act[1]),
        .b1  (coef_act[2]),
        .y   (f_y)
    );

    assign m_data = f_y;

endmodule
